// File: rtl/sharpen_pkg.sv
// Shared types and default geometry for the 3x3 sharpen window controller.
package sharpen_pkg;

    localparam int unsigned DEF_IMG_W = 256;
    localparam int unsigned DEF_IMG_H = 256;
    localparam int unsigned DEF_PIX_W = 8;
    localparam int unsigned DEF_KW    = 17;

    // Counter width able to hold 0..n-1, never narrower than one bit
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned DEF_COL_W = cnt_w(DEF_IMG_W);
    localparam int unsigned DEF_ROW_W = cnt_w(DEF_IMG_H);
    localparam int unsigned DEF_CNT_W = cnt_w(DEF_IMG_W * DEF_IMG_H);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    // Attributes of the output pixel currently held in the window
    typedef struct packed {
        logic border;
        logic sof;
        logic eof;
    } out_tag_t;

endpackage

// File: rtl/sharpen_line_buf.sv
// One-line delay for the window: a pixel written on step t is read back on step t+DEPTH.
module sharpen_line_buf
    import sharpen_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_IMG_W,
    parameter int unsigned WIDTH = DEF_PIX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout_c
);

    localparam int unsigned AW = cnt_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    ptr;

    // Read-before-write on the same slot gives exactly DEPTH steps of delay
    assign dout_c = mem[ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            mem[ptr] <= din;
        end
    end

endmodule

// File: rtl/sharpen_window_ctrl.sv
// Raster-stream controller feeding a 3x3 window to an external sharpen kernel;
// border pixels bypass the kernel and the output frame keeps the input geometry.
module sharpen_window_ctrl
    import sharpen_pkg::*;
#(
    parameter int unsigned IMG_W = DEF_IMG_W,
    parameter int unsigned IMG_H = DEF_IMG_H,
    parameter int unsigned PIX_W = DEF_PIX_W,
    parameter int unsigned KW    = DEF_KW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [PIX_W-1:0] s_data,
    input  logic             s_sof,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [PIX_W-1:0] m_data,
    output logic             m_sof,
    output logic             m_eof,
    output logic [KW-1:0]    win_p0,
    output logic [KW-1:0]    win_p1,
    output logic [KW-1:0]    win_p2,
    output logic [KW-1:0]    win_p3,
    output logic [KW-1:0]    win_p4,
    output logic [KW-1:0]    win_p5,
    output logic [KW-1:0]    win_p6,
    output logic [KW-1:0]    win_p7,
    output logic [KW-1:0]    win_p8,
    input  logic [KW-1:0]    kern_result,
    output logic             busy,
    output logic             frame_err
);

    localparam int unsigned COL_W = cnt_w(IMG_W);
    localparam int unsigned ROW_W = cnt_w(IMG_H);
    localparam int unsigned CNT_W = cnt_w(IMG_W * IMG_H);
    localparam logic [CNT_W-1:0] LAST_IN  = CNT_W'(IMG_W * IMG_H - 1);
    localparam logic [CNT_W-1:0] FILL_END = CNT_W'(IMG_W);

    state_e           state, state_next;
    logic             adv_c, step_c, produce_c, cnt_clr_c;
    logic [PIX_W-1:0] step_pix_c;
    logic [CNT_W-1:0] in_cnt;
    logic [COL_W-1:0] out_col;
    logic [ROW_W-1:0] out_row;
    logic [PIX_W-1:0] win [9];
    logic [PIX_W-1:0] lb0_out_c, lb1_out_c;
    logic             pend_vld;
    out_tag_t         pend_tag, tag_c;
    logic             unused_kern_hi;

    assign adv_c          = !m_valid || m_ready;
    assign busy           = (state != ST_IDLE);
    assign unused_kern_hi = ^kern_result[KW-1:PIX_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Next state plus step/produce strobes; DRAIN steps push zeros through the window
    always_comb begin
        state_next = state;
        s_ready    = 1'b0;
        step_c     = 1'b0;
        produce_c  = 1'b0;
        cnt_clr_c  = 1'b0;
        step_pix_c = s_data;
        case (state)
            ST_IDLE: begin
                s_ready = adv_c;
                if (s_valid && adv_c && s_sof) begin
                    step_c     = 1'b1;
                    state_next = ST_FILL;
                end
            end
            ST_FILL: begin
                s_ready = adv_c;
                if (s_valid && adv_c) begin
                    step_c = 1'b1;
                    if (in_cnt == FILL_END) state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                s_ready = adv_c;
                if (s_valid && adv_c) begin
                    step_c    = 1'b1;
                    produce_c = 1'b1;
                    if (in_cnt == LAST_IN) begin
                        cnt_clr_c  = 1'b1;
                        state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                step_pix_c = '0;
                if (adv_c) begin
                    step_c    = 1'b1;
                    produce_c = 1'b1;
                    if (in_cnt == FILL_END) begin
                        cnt_clr_c  = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        tag_c        = '0;
        tag_c.sof    = (out_row == '0) && (out_col == '0);
        tag_c.eof    = (out_row == ROW_W'(IMG_H - 1)) && (out_col == COL_W'(IMG_W - 1));
        tag_c.border = (out_row == '0) || (out_row == ROW_W'(IMG_H - 1)) ||
                       (out_col == '0) || (out_col == COL_W'(IMG_W - 1));
    end

    sharpen_line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (step_c),
        .din    (step_pix_c),
        .dout_c (lb0_out_c)
    );

    sharpen_line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (step_c),
        .din    (lb0_out_c),
        .dout_c (lb1_out_c)
    );

    // Window shift, input/output position counters and the pending-result stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_cnt   <= '0;
            out_col  <= '0;
            out_row  <= '0;
            pend_vld <= 1'b0;
            pend_tag <= '0;
            for (int i = 0; i < 9; i++) win[i] <= '0;
        end else begin
            if (step_c) begin
                in_cnt <= cnt_clr_c ? '0 : in_cnt + CNT_W'(1);
                for (int r = 0; r < 3; r++) begin
                    win[3*r]   <= win[3*r+1];
                    win[3*r+1] <= win[3*r+2];
                end
                win[2] <= lb1_out_c;
                win[5] <= lb0_out_c;
                win[8] <= step_pix_c;
            end
            if (produce_c) begin
                if (out_col == COL_W'(IMG_W - 1)) begin
                    out_col <= '0;
                    out_row <= (out_row == ROW_W'(IMG_H - 1)) ? '0 : out_row + ROW_W'(1);
                end else begin
                    out_col <= out_col + COL_W'(1);
                end
            end
            if (adv_c) begin
                pend_vld <= produce_c;
                pend_tag <= tag_c;
            end
        end
    end

    // Kernel result is read one clock after the window settles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_sof     <= 1'b0;
            m_eof     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= s_valid && s_ready && s_sof && ((state == ST_FILL) || (state == ST_RUN));
            if (adv_c) begin
                m_valid <= pend_vld;
                if (pend_vld) begin
                    m_data <= pend_tag.border ? win[4] : kern_result[PIX_W-1:0];
                    m_sof  <= pend_tag.sof;
                    m_eof  <= pend_tag.eof;
                end else begin
                    m_sof  <= 1'b0;
                    m_eof  <= 1'b0;
                end
            end
        end
    end

    assign win_p0 = KW'(win[0]);
    assign win_p1 = KW'(win[1]);
    assign win_p2 = KW'(win[2]);
    assign win_p3 = KW'(win[3]);
    assign win_p4 = KW'(win[4]);
    assign win_p5 = KW'(win[5]);
    assign win_p6 = KW'(win[6]);
    assign win_p7 = KW'(win[7]);
    assign win_p8 = KW'(win[8]);

endmodule
